// File: rtl/semaforo_pkg.sv
// semaforo_pkg -- shared definitions for the multi-approach traffic light.
//   LUZ_*      : 3-bit one-hot light encodings driven on each approach slice
//   estado_t   : controller phase (VERDE, AMARELO, VERMELHO_TOTAL)
//   duracao_t  : 8-bit phase duration / phase counter type
package semaforo_pkg;

  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;

  typedef enum logic [1:0] {
    VERDE,
    AMARELO,
    VERMELHO_TOTAL
  } estado_t;

  typedef logic [7:0] duracao_t;

  localparam duracao_t DURACAO_MAX = 8'd255;

endpackage

// File: rtl/arbitro_rr.sv
// arbitro_rr -- combinational round-robin finder.
//   pend   : pending request per approach
//   via    : current owner; the search starts at via+1 and wraps
//   prox   : first pending approach found (0 when none)
//   valido : at least one pending approach other than via
module arbitro_rr #(
  parameter int unsigned N_VIAS = 2
) (
  input  logic [N_VIAS-1:0] pend,
  input  logic [2:0]        via,
  output logic [2:0]        prox,
  output logic              valido
);

  logic [7:0] pend_ext;
  logic [3:0] cand;

  // Offsets 1..N_VIAS-1 only: the owner itself is never a candidate.
  always_comb begin
    pend_ext = 8'(pend);
    prox     = '0;
    valido   = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i < N_VIAS; i++) begin
      cand = {1'b0, via} + 4'(i);
      if (cand >= 4'(N_VIAS)) cand = cand - 4'(N_VIAS);
      if (!valido && pend_ext[cand[2:0]]) begin
        prox   = cand[2:0];
        valido = 1'b1;
      end
    end
  end

endmodule

// File: rtl/semaforo_multi.sv
// semaforo_multi -- traffic light controller for N_VIAS approaches sharing one
// green. Sequence per owner: VERDE -> AMARELO -> VERMELHO_TOTAL -> next owner.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bt   : request button per approach (level sampled)
//   luz  : light per approach, approach k on bits [3k+2:3k]
//   via  : approach owning green/yellow (kept during all-red)
//   pend : latched pending requests
// MODO=0 rotates on fixed time; MODO=1 leaves green only when another
// approach is pending, serving the next one round-robin.
module semaforo_multi
  import semaforo_pkg::*;
#(
  parameter int unsigned N_VIAS     = 2,
  parameter duracao_t    T_VERDE    = 8'd1,
  parameter duracao_t    T_AMARELO  = 8'd3,
  parameter duracao_t    T_VERMELHO = 8'd2,
  parameter int unsigned MODO       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_VIAS-1:0]     bt,
  output logic [3*N_VIAS-1:0]   luz,
  output logic [2:0]            via,
  output logic [N_VIAS-1:0]     pend
);

  estado_t           estado, estado_n;
  duracao_t          cnt, cnt_n;
  logic [2:0]        via_n;
  logic [2:0]        prox, prox_n;
  logic [N_VIAS-1:0] pend_n;
  logic [2:0]        arb_prox;
  logic              arb_valido;
  logic [3:0]        via_inc;
  logic              troca;

  arbitro_rr #(.N_VIAS(N_VIAS)) u_arb (
    .pend   (pend),
    .via    (via),
    .prox   (arb_prox),
    .valido (arb_valido)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= VERDE;
      via    <= '0;
      cnt    <= 8'd1;
      pend   <= '0;
      prox   <= '0;
    end else begin
      estado <= estado_n;
      via    <= via_n;
      cnt    <= cnt_n;
      pend   <= pend_n;
      prox   <= prox_n;
    end
  end

  always_comb begin
    estado_n = estado;
    via_n    = via;
    prox_n   = prox;
    troca    = 1'b0;
    pend_n   = pend | bt;

    via_inc = {1'b0, via} + 4'd1;
    if (via_inc >= 4'(N_VIAS)) via_inc = '0;

    case (estado)
      VERDE: begin
        // The owner's own button is meaningless while it already has green.
        for (int unsigned k = 0; k < N_VIAS; k++) begin
          if (3'(k) == via) pend_n[k] = 1'b0;
        end
        if (MODO == 0) begin
          if (cnt == T_VERDE) begin
            estado_n = AMARELO;
            prox_n   = via_inc[2:0];
            troca    = 1'b1;
          end
        end else if (cnt >= T_VERDE && arb_valido) begin
          estado_n = AMARELO;
          prox_n   = arb_prox;
          troca    = 1'b1;
        end
      end
      AMARELO: begin
        if (cnt == T_AMARELO) begin
          estado_n = VERMELHO_TOTAL;
          troca    = 1'b1;
        end
      end
      VERMELHO_TOTAL: begin
        if (cnt == T_VERMELHO) begin
          estado_n = VERDE;
          via_n    = prox;
          troca    = 1'b1;
          // Entering green serves the request; a simultaneous press is dropped.
          for (int unsigned k = 0; k < N_VIAS; k++) begin
            if (3'(k) == prox) pend_n[k] = 1'b0;
          end
        end
      end
      default: begin
        estado_n = VERDE;
        troca    = 1'b1;
      end
    endcase

    // Actuated green parks the counter at T_VERDE while waiting for demand.
    if (troca) begin
      cnt_n = 8'd1;
    end else if (estado == VERDE && MODO != 0 && cnt >= T_VERDE) begin
      cnt_n = cnt;
    end else if (cnt != DURACAO_MAX) begin
      cnt_n = cnt + 8'd1;
    end else begin
      cnt_n = cnt;
    end
  end

  always_comb begin
    luz = '0;
    for (int unsigned k = 0; k < N_VIAS; k++) begin
      luz[3*k +: 3] = LUZ_VERMELHO;
      if (3'(k) == via) begin
        if (estado == VERDE)   luz[3*k +: 3] = LUZ_VERDE;
        if (estado == AMARELO) luz[3*k +: 3] = LUZ_AMARELO;
      end
    end
  end

endmodule

// File: doc/semaforo_multi.md
SEMAFORO_MULTI -- requirements
Module: semaforo_multi

Interface
REQ-001 Parameter N_VIAS, default 2: number of approaches; legal range 2..8.
REQ-002 Parameter T_VERDE, default 8'd1: minimum green duration in cycles; legal range 1..255.
REQ-003 Parameter T_AMARELO, default 8'd3: yellow duration in cycles; legal range 1..255.
REQ-004 Parameter T_VERMELHO, default 8'd2: all-red clearance duration in cycles; legal range 1..255.
REQ-005 Parameter MODO, default 0: 0 = fixed-time rotation; 1 = actuated (request-driven).
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 bt  input  N_VIAS  request button per approach, level-sampled each rising edge.
REQ-009 luz  output  3*N_VIAS  light per approach; approach k occupies bits [3k+2:3k]; encodings 3'b001 green, 3'b010 yellow, 3'b100 red.
REQ-010 via  output  3  index of the approach currently owning green/yellow; holds the last owner during all-red.
REQ-011 pend  output  N_VIAS  latched pending requests.

Function
REQ-012 FSM states: VERDE, AMARELO, VERMELHO_TOTAL; one 8-bit phase counter.
REQ-013 At any cycle, at most one approach is non-red; every other approach shows 3'b100.
REQ-014 Counter loads 1 on entry to each state and increments each cycle; the state exits when counter == its duration, so each state lasts exactly T cycles.
REQ-015 MODO=0: VERDE exits after exactly T_VERDE cycles; next approach = (via+1) mod N_VIAS.
REQ-016 MODO=1: VERDE exits once counter >= T_VERDE and pend has at least one bit set other than via; otherwise green holds indefinitely with the counter saturated at T_VERDE.
REQ-017 MODO=1 next approach: first set pend bit found searching round-robin from via+1 upward with wrap.
REQ-018 The next approach is chosen at the VERDE->AMARELO transition and stored; later requests do not change it.
REQ-019 AMARELO: via's light = 3'b010 for exactly T_AMARELO cycles, then VERMELHO_TOTAL.
REQ-020 VERMELHO_TOTAL: all lights 3'b100 for exactly T_VERMELHO cycles; then via = stored next and the state goes to VERDE.
REQ-021 pend[k] is set on any edge where bt[k]=1; a button held for several cycles counts as one request.
REQ-022 pend[k] is cleared on the edge where approach k enters VERDE; if bt[k]=1 on that same edge, clear wins.
REQ-023 bt[via]=1 while via is in VERDE is ignored (pend[via] stays 0); in AMARELO/VERMELHO_TOTAL it is latched.
REQ-024 In MODO=0, pend is maintained and visible on the output but does not affect sequencing.
REQ-025 Counter never wraps: it saturates at 255.

Reset
REQ-026 On an rst=1 edge: state VERDE, via=0, counter=1, pend=0, stored next=0.
REQ-027 Reset values: luz[2:0]=3'b001, all other approaches 3'b100, via=0, pend=0.
REQ-028 Reset asserted mid-phase overrides every transition on that edge; the first post-reset green lasts full T_VERDE.
REQ-029 bt is ignored while rst=1.

Structure
REQ-030 Package semaforo_pkg holds the light encodings (VERDE/AMARELO/VERMELHO 3-bit constants), the state enum and the 8-bit duration type.
REQ-031 One sub-module arbitro_rr (N_VIAS-wide round-robin finder: pend, via -> next, valid) is instantiated once.
REQ-032 All registers are in semaforo_multi; luz is decoded combinationally from state and via.

Verification
REQ-033 Defaults, MODO=0, rst high for 8 time units then low: after reset, A green 1 cycle, yellow 3, all-red 2, then B green 1 cycle; the sequence repeats with period 12 cycles.
REQ-034 MODO=1, N_VIAS=2, no bt: approach 0 stays green for 50 cycles; pend=0.
REQ-035 MODO=1, bt[1] pulsed 1 cycle at cycle 5: pend[1]=1 next edge; yellow from cycle 6 for 3 cycles, all-red for 2, approach 1 green at cycle 11, pend[1]=0.
REQ-036 MODO=1, N_VIAS=4, via=1, bt[0] and bt[3] pressed together: approach 3 is served first, then approach 0 (wrap-around).
REQ-037 bt[via] held during green -> pend unchanged; rst pulsed during AMARELO -> approach 0 green with the full T_VERDE on the next edge.
REQ-038 Every cycle, the bench checks that at most one approach is non-red.
